// File: rtl/inst_fetch_pkg.sv
// Shared core constants and the IF/ID pipeline bundle used by the fetch stage.
package inst_fetch_pkg;

    localparam logic [31:0] DefaultResetPc = 32'h0000_0000;
    localparam logic [31:0] DefaultNopWord = 32'h0000_0000;
    localparam logic [31:0] ExcpVector     = 32'h0000_0180;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [31:0] inst;
        logic        addr_err;
    } if_id_t;

endpackage

// File: rtl/inst_fetch_if_id_reg.sv
// IF/ID pipeline register: holds by default, loads on capture, bubbles on flush.
module inst_fetch_if_id_reg
    import inst_fetch_pkg::*;
#(
    parameter logic [31:0] NOP_WORD = DefaultNopWord
) (
    input  logic   clk,
    input  logic   rst_n,
    input  logic   flush_i,
    input  logic   capture_i,
    input  if_id_t data_i,
    output if_id_t data_o
);

    if_id_t if_id_q, if_id_d, bubble;

    always_comb begin
        bubble.valid    = 1'b0;
        bubble.pc       = 32'h0;
        bubble.inst     = NOP_WORD;
        bubble.addr_err = 1'b0;
    end

    always_comb begin
        if_id_d = if_id_q;
        if (flush_i) begin
            if_id_d = bubble;
        end else if (capture_i) begin
            if_id_d = data_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            if_id_q <= bubble;
        end else begin
            if_id_q <= if_id_d;
        end
    end

    assign data_o = if_id_q;

endmodule

// File: rtl/inst_fetch.sv
// MIPS fetch stage: PC, next-PC selection with delay-slot redirect, exception
// redirect, misaligned-fetch detection and a fetched-instruction counter.
module inst_fetch
    import inst_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DefaultResetPc,
    parameter logic [31:0] NOP_WORD = DefaultNopWord
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall_i,
    input  logic        branch_taken_i,
    input  logic [31:0] branch_target_i,
    input  logic        excp_flush_i,
    input  logic [31:0] excp_target_i,
    output logic        inst_ce_o,
    output logic [31:0] inst_addr_o,
    input  logic [31:0] inst_i,
    output logic        id_valid_o,
    output logic [31:0] id_pc_o,
    output logic [31:0] id_inst_o,
    output logic        id_addr_err_o,
    output logic [31:0] fetch_count_o
);

    logic        ce_q, ce_d;
    logic [31:0] pc_q, pc_d;
    logic        pend_q, pend_d;
    logic [31:0] pend_target_q, pend_target_d;
    logic [31:0] count_q, count_d;

    logic   misaligned, capture, flush;
    if_id_t cap_data, if_id;

    assign misaligned = (pc_q[1:0] != 2'b00);
    assign flush      = ce_q & excp_flush_i;
    assign capture    = ce_q & ~excp_flush_i & ~stall_i;

    always_comb begin
        cap_data.valid    = 1'b1;
        cap_data.pc       = pc_q;
        cap_data.inst     = misaligned ? NOP_WORD : inst_i;
        cap_data.addr_err = misaligned;
    end

    always_comb begin
        ce_d          = 1'b1;
        pc_d          = pc_q;
        pend_d        = pend_q;
        pend_target_d = pend_target_q;
        count_d       = count_q;
        if (ce_q) begin
            if (excp_flush_i) begin
                pc_d   = excp_target_i;
                pend_d = 1'b0;
            end else if (branch_taken_i && !stall_i) begin
                pc_d   = branch_target_i;
                pend_d = 1'b0;
            end else if (branch_taken_i) begin
                // Branch resolved while IF is held: redirect once the stall lifts.
                pend_d        = 1'b1;
                pend_target_d = branch_target_i;
            end else if (stall_i) begin
                pc_d = pc_q;
            end else if (pend_q) begin
                pc_d   = pend_target_q;
                pend_d = 1'b0;
            end else begin
                pc_d = pc_q + 32'd4;
            end
            if (capture) begin
                count_d = count_q + 32'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ce_q          <= 1'b0;
            pc_q          <= RESET_PC;
            pend_q        <= 1'b0;
            pend_target_q <= 32'h0;
            count_q       <= 32'h0;
        end else begin
            ce_q          <= ce_d;
            pc_q          <= pc_d;
            pend_q        <= pend_d;
            pend_target_q <= pend_target_d;
            count_q       <= count_d;
        end
    end

    inst_fetch_if_id_reg #(
        .NOP_WORD (NOP_WORD)
    ) u_if_id_reg (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush_i   (flush),
        .capture_i (capture),
        .data_i    (cap_data),
        .data_o    (if_id)
    );

    // A misaligned PC never reaches memory; the slot carries an AdEL marker instead.
    assign inst_ce_o     = ce_q & ~misaligned;
    assign inst_addr_o   = pc_q;
    assign id_valid_o    = if_id.valid;
    assign id_pc_o       = if_id.pc;
    assign id_inst_o     = if_id.inst;
    assign id_addr_err_o = if_id.addr_err;
    assign fetch_count_o = count_q;

endmodule

// File: tb/tb_inst_fetch.sv
// Directed bench for inst_fetch with a combinational word-indexed instruction memory.
module tb_inst_fetch;

    logic        clk;
    logic        rst_n;
    logic        stall_i;
    logic        branch_taken_i;
    logic [31:0] branch_target_i;
    logic        excp_flush_i;
    logic [31:0] excp_target_i;
    logic        inst_ce_o;
    logic [31:0] inst_addr_o;
    logic [31:0] inst_i;
    logic        id_valid_o;
    logic [31:0] id_pc_o;
    logic [31:0] id_inst_o;
    logic        id_addr_err_o;
    logic [31:0] fetch_count_o;

    int errors = 0;
    int checks = 0;

    inst_fetch dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .stall_i         (stall_i),
        .branch_taken_i  (branch_taken_i),
        .branch_target_i (branch_target_i),
        .excp_flush_i    (excp_flush_i),
        .excp_target_i   (excp_target_i),
        .inst_ce_o       (inst_ce_o),
        .inst_addr_o     (inst_addr_o),
        .inst_i          (inst_i),
        .id_valid_o      (id_valid_o),
        .id_pc_o         (id_pc_o),
        .id_inst_o       (id_inst_o),
        .id_addr_err_o   (id_addr_err_o),
        .fetch_count_o   (fetch_count_o)
    );

    // Word at index i holds 0x1000_0000 + i.
    assign inst_i = 32'h1000_0000 + (inst_addr_o >> 2);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_id(input string tag, input logic v, input logic [31:0] pc,
                          input logic [31:0] inst, input logic err);
        chk({tag, ".valid"}, {31'h0, id_valid_o}, {31'h0, v});
        chk({tag, ".pc"}, id_pc_o, pc);
        chk({tag, ".inst"}, id_inst_o, inst);
        chk({tag, ".err"}, {31'h0, id_addr_err_o}, {31'h0, err});
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, ".ce"}, {31'h0, inst_ce_o}, 32'h0);
        chk({tag, ".addr"}, inst_addr_o, 32'h0);
        chk_id(tag, 1'b0, 32'h0, 32'h0, 1'b0);
        chk({tag, ".count"}, fetch_count_o, 32'h0);
    endtask

    initial begin
        rst_n           = 1'b0;
        stall_i         = 1'b0;
        branch_taken_i  = 1'b0;
        branch_target_i = 32'h0;
        excp_flush_i    = 1'b0;
        excp_target_i   = 32'h0;

        step();
        chk_reset("reset");
        step();
        chk_reset("reset_hold");
        rst_n = 1'b1;

        // Sequential fetch
        step();
        chk("c1.ce", {31'h0, inst_ce_o}, 32'h1);
        chk("c1.addr", inst_addr_o, 32'h0);
        chk("c1.count", fetch_count_o, 32'h0);
        step();
        chk_id("seq0", 1'b1, 32'h0, 32'h1000_0000, 1'b0);
        chk("seq0.addr", inst_addr_o, 32'h4);
        step();
        chk_id("seq1", 1'b1, 32'h4, 32'h1000_0001, 1'b0);
        chk("seq1.addr", inst_addr_o, 32'h8);
        step();
        chk("seq2.count", fetch_count_o, 32'd3);
        chk("seq2.addr", inst_addr_o, 32'hC);
        step();
        step();
        chk("pre_br.addr", inst_addr_o, 32'h14);

        // Branch with delay slot
        branch_taken_i = 1'b1; branch_target_i = 32'h100;
        step();
        branch_taken_i = 1'b0;
        chk_id("dslot", 1'b1, 32'h14, 32'h1000_0005, 1'b0);
        chk("br.addr", inst_addr_o, 32'h100);
        chk("br.count", fetch_count_o, 32'd6);
        step();
        chk_id("br_tgt", 1'b1, 32'h100, 32'h1000_0040, 1'b0);
        chk("br_tgt.addr", inst_addr_o, 32'h104);

        // Stall with branch in second stall cycle
        stall_i = 1'b1;
        step();
        chk("st1.addr", inst_addr_o, 32'h104);
        branch_taken_i = 1'b1; branch_target_i = 32'h200;
        step();
        branch_taken_i = 1'b0;
        chk("st2.addr", inst_addr_o, 32'h104);
        chk_id("st2", 1'b1, 32'h100, 32'h1000_0040, 1'b0);
        step();
        chk("st3.addr", inst_addr_o, 32'h104);
        chk("st3.count", fetch_count_o, 32'd7);
        stall_i = 1'b0;
        step();
        chk_id("st_rel", 1'b1, 32'h104, 32'h1000_0041, 1'b0);
        chk("st_rel.addr", inst_addr_o, 32'h200);
        chk("st_rel.count", fetch_count_o, 32'd8);
        step();
        chk("st_rel2.addr", inst_addr_o, 32'h204);

        // Exception while stalled with a pending redirect
        stall_i = 1'b1; branch_taken_i = 1'b1; branch_target_i = 32'h300;
        step();
        branch_taken_i = 1'b0;
        excp_flush_i = 1'b1; excp_target_i = 32'h180;
        step();
        excp_flush_i = 1'b0; stall_i = 1'b0;
        chk("ex.addr", inst_addr_o, 32'h180);
        chk_id("ex", 1'b0, 32'h0, 32'h0, 1'b0);
        chk("ex.count", fetch_count_o, 32'd9);
        step();
        chk_id("ex_vec", 1'b1, 32'h180, 32'h1000_0060, 1'b0);
        chk("ex_vec.addr", inst_addr_o, 32'h184);

        // Misaligned branch target
        branch_taken_i = 1'b1; branch_target_i = 32'h102;
        step();
        branch_taken_i = 1'b0;
        chk("mis.addr", inst_addr_o, 32'h102);
        chk("mis.ce", {31'h0, inst_ce_o}, 32'h0);
        step();
        chk_id("mis", 1'b1, 32'h102, 32'h0, 1'b1);
        chk("mis_next.addr", inst_addr_o, 32'h106);
        chk("mis.count", fetch_count_o, 32'd12);
        branch_taken_i = 1'b1; branch_target_i = 32'h400;
        step();
        branch_taken_i = 1'b0;
        step();
        chk_id("recov", 1'b1, 32'h400, 32'h1000_0100, 1'b0);
        chk("recov.ce", {31'h0, inst_ce_o}, 32'h1);

        // Async reset with a redirect pending
        stall_i = 1'b1; branch_taken_i = 1'b1; branch_target_i = 32'h500;
        step();
        branch_taken_i = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk_reset("async_rst");
        step();
        stall_i = 1'b0;
        rst_n = 1'b1;
        step();
        chk("rst_c1.ce", {31'h0, inst_ce_o}, 32'h1);
        chk("rst_c1.addr", inst_addr_o, 32'h0);
        step();
        chk_id("rst_seq0", 1'b1, 32'h0, 32'h1000_0000, 1'b0);
        chk("rst_seq0.addr", inst_addr_o, 32'h4);
        chk("rst_seq0.count", fetch_count_o, 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
